dcache_nway: RTL
================

# dcache_nway

Parametrised N-way set-associative, write-back, write-allocate data cache with multi-word lines and a handshaked, word-serial memory port. It sits between the core's memory stage and main memory, replacing the fixed 2-way, single-word-line cache. The core sees a combinational hit path and a `stall` output. Misses run through a writeback/refill state machine that moves whole lines with a per-word request/acknowledge protocol.

## Interface
- `XLEN`, 32, data/address width.
- `SETS`, 128, number of sets; power of two, ≥2.
- `WAYS`, 2, associativity; power of two, ≥2.
- `WORDS_PER_LINE`, 4, 32-bit words per line; power of two, ≥1.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `cpu_req` in 1 — access valid this cycle.
- `A` in XLEN — byte address.
- `WD` in XLEN — store data, right-aligned.
- `WE` in 1 — store when 1, load when 0.
- `AddressingControl` in 3 — 000 SB, 001 SH, 010 SW; other codes are treated as SW.
- `cache_dout` out 32 — raw aligned word; load extension is done outside this block.
- `stall` out 1 — core must hold all inputs while high.
- `mem_req` out 1 — memory transfer request.
- `mem_we` out 1 — 1 for writeback, 0 for refill.
- `mem_addr` out XLEN — word-aligned address.
- `mem_wd` out 32 — writeback data.
- `mem_rd` in 32 — refill data.
- `mem_ack` in 1 — one word transferred this cycle.
- `hit_count`, `miss_count`, `wb_count` out 32 each — see Configuration.

## Operation
- Address split:
  - byte offset `A[1:0]`
  - word offset `A[2+:WB]` where WB = log2(WORDS_PER_LINE)
  - set `A[2+WB+:SB]` where SB = log2(SETS)
  - tag = remaining upper bits
- Per way, per set: valid, dirty, tag, line data. Per set: round-robin victim pointer, log2(WAYS) bits.
- Lookup is combinational in IDLE with `cpu_req` high.
  - Hit in way w: `cache_dout` = selected word of way w.
  - Store hit: the byte/half/word is merged using `AddressingControl` and `A[1:0]`, written at the clock edge, and dirty[w] is set.
  - `stall`=0 on a hit.
- Miss: `stall`=1 combinationally in the same cycle. The victim is the first invalid way, lowest index first; otherwise the way at the set's victim pointer.
- FSM states IDLE, WRITEBACK, REFILL:
  - IDLE→WRITEBACK on a miss when the victim is valid and dirty.
  - IDLE→REFILL on a miss otherwise.
  - WRITEBACK: stream the victim line, word 0 to word N-1, to `{victim_tag, set, word, 2'b00}`. An internal word counter advances on each `mem_ack`. After the last ack, clear dirty and go to REFILL.
  - REFILL: read `{tag, set, word, 2'b00}` for word 0 to word N-1, writing each acked word into the victim way. On the last ack, set tag and valid, clear dirty, advance the victim pointer modulo WAYS, and go to IDLE.
  - Back in IDLE the held request re-looks up and hits. A store miss therefore completes as a store hit (write-allocate).
- `stall`=1 in every non-IDLE state, regardless of `cpu_req`.
- With `cpu_req`=0 in IDLE: `stall`=0 and no state changes.

## Timing
- Reset values:
  - all valid, dirty and victim pointers 0
  - FSM in IDLE
  - `stall`, `mem_req`, `mem_we` = 0
  - `mem_addr`, `mem_wd` = 0
  - counters 0
  - `cache_dout` = 0 while no way hits
- Hit latency is 0 cycles; the result is valid in the request cycle.
- Clean miss, with `mem_ack` in every cycle: `stall` is high for WORDS_PER_LINE+1 cycles.
- Dirty miss: add WORDS_PER_LINE cycles.
- Memory handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wd` are registered.
  - They stay stable until the cycle in which `mem_ack` is sampled high.
  - `mem_ack` arriving while `mem_req`=0 is ignored.
- WRITEBACK→REFILL: `mem_req` stays high with no gap and `mem_we` drops.
- Reset during WRITEBACK or REFILL aborts the transfer: `mem_req` drops asynchronously, nothing is installed, and dirty data is discarded.

## Configuration
- `DCACHE_PERF_EN` defined:
  - `hit_count` increments on each IDLE cycle with `cpu_req` and a hit, including the post-refill hit.
  - `miss_count` increments on each IDLE→WRITEBACK/REFILL transition.
  - `wb_count` increments on each WRITEBACK entry.
  - All three counters wrap at 2^32.
- Not defined: the counters are tied to 0 and no counter flops exist.

## Structure
- `dcache_pkg` holds:
  - the FSM state enum
  - `AddressingControl` store codes
  - localparams and functions for WB, SB, tag width and victim-pointer width
- Sub-module `dcache_store_merge`: combinational old word + `WD` + control + byte offset → merged word. It is used on store hits.

## Test plan
Defaults apply: set = `A[10:4]`, tag = `A[31:11]`.
1. Cold load of 0x0000_1000 with memory returning 0x11,0x22,0x33,0x44 and ack every cycle → `stall` high 5 cycles, `mem_addr` 0x1000,0x1004,0x1008,0x100C, `cache_dout`=0x22 when re-issued at 0x1004; `hit_count`=1, `miss_count`=1.
2. SB 0xAB to 0x0000_1002 after scenario 1 → same-cycle hit, no stall; word 0x1000 reads 0x00AB_0011.
3. Fill 0x1000, 0x1800 and 0x2000 in one set with 0x1000 dirty → third miss writes back 4 words starting 0x1000 (`mem_we`=1), then refills 0x2000; `wb_count`=1.
4. `mem_ack` held low 3 cycles mid-refill → `mem_addr` and `mem_req` remain stable; the counter does not advance.
5. Assert `rst` mid-WRITEBACK → `mem_req`=0 immediately; all subsequent accesses miss.
6. Build without `DCACHE_PERF_EN`, run scenario 1 → all counters read 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the N-way data cache.
// Holds the miss FSM state enum, the store-width codes carried on
// AddressingControl, and constant functions that derive the address
// field widths from the cache parameters.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } state_t;

  // Store widths; any other code behaves as a full word store.
  localparam logic [2:0] AC_SB = 3'b000;
  localparam logic [2:0] AC_SH = 3'b001;
  localparam logic [2:0] AC_SW = 3'b010;

  // Word-offset bits inside a line (0 for single-word lines).
  function automatic int calc_wb(input int words);
    return (words > 1) ? $clog2(words) : 0;
  endfunction

  // Set-index bits.
  function automatic int calc_sb(input int sets);
    return $clog2(sets);
  endfunction

  // Tag bits: whatever is left above set and word offset.
  function automatic int calc_tagw(input int xlen, input int sets, input int words);
    return xlen - 2 - calc_wb(words) - calc_sb(sets);
  endfunction

  // Round-robin victim pointer bits.
  function automatic int calc_vpw(input int ways);
    return $clog2(ways);
  endfunction

  // Transfer word counter needs at least one bit even for 1-word lines.
  function automatic int calc_cntw(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/dcache_store_merge.sv
// Combinational store merge for a store hit.
// Ports:
//   old_word - current 32-bit word held in the cache
//   wd       - right-aligned store data
//   ctrl     - AddressingControl (SB / SH / SW, others act as SW)
//   boff     - byte offset A[1:0]
//   merged   - word to write back into the line
module dcache_store_merge
  import dcache_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wd,
  input  logic [2:0]  ctrl,
  input  logic [1:0]  boff,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (ctrl)
      AC_SB:   merged[{boff, 3'b000} +: 8]     = wd[7:0];
      // Halfword lane chosen by boff[1]; boff[0] is ignored.
      AC_SH:   merged[{boff[1], 4'b0000} +: 16] = wd[15:0];
      default: merged = wd;
    endcase
  end

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative, write-back, write-allocate data cache with
// multi-word lines and a word-serial request/ack memory port.
// Optional feature macro: DCACHE_PERF_EN (hit/miss/writeback counters).
// Ports:
//   clk, rst                  - clock, async active-high reset
//   cpu_req, A, WD, WE        - core access (held stable while stall=1)
//   AddressingControl         - store width code
//   cache_dout                - raw aligned word of the hitting way, else 0
//   stall                     - miss in progress / miss detected
//   mem_req, mem_we, mem_addr, mem_wd - registered memory request
//   mem_rd, mem_ack           - memory response, one word per ack
//   hit_count, miss_count, wb_count   - performance counters
module dcache_nway
  import dcache_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int SETS           = 128,
  parameter int WAYS           = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] WD,
  input  logic            WE,
  input  logic [2:0]      AddressingControl,
  output logic [31:0]     cache_dout,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [31:0]     mem_wd,
  input  logic [31:0]     mem_rd,
  input  logic            mem_ack,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count,
  output logic [31:0]     wb_count
);

  localparam int WB   = calc_wb(WORDS_PER_LINE);
  localparam int SB   = calc_sb(SETS);
  localparam int TAGW = calc_tagw(XLEN, SETS, WORDS_PER_LINE);
  localparam int VPW  = calc_vpw(WAYS);
  localparam int WBW  = calc_cntw(WORDS_PER_LINE);
  localparam logic [WBW-1:0] LAST_WORD = WBW'(WORDS_PER_LINE - 1);

  // Storage
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [VPW-1:0]  vptr_q  [SETS];
  logic [TAGW-1:0] tags    [WAYS][SETS];
  logic [31:0]     data    [WAYS][SETS][WORDS_PER_LINE];

  // Miss context
  state_t          state_q;
  logic [WBW-1:0]  wcnt_q;
  logic [VPW-1:0]  vic_q;
  logic [SB-1:0]   set_q;
  logic [TAGW-1:0] mtag_q;

  // Address split
  logic [SB-1:0]   set_idx;
  logic [TAGW-1:0] tag_in;
  logic [WBW-1:0]  word_off;

  assign set_idx = A[2+WB +: SB];
  assign tag_in  = A[XLEN-1 -: TAGW];

  if (WB > 0) begin : g_woff
    assign word_off = A[2 +: WBW];
  end else begin : g_woff0
    assign word_off = '0;
  end

  // Lookup
  logic [WAYS-1:0] hit_vec;
  logic [VPW-1:0]  hit_way;
  logic            hit;
  logic [31:0]     hit_word;
  logic [31:0]     merged;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[set_idx][w] && (tags[w][set_idx] == tag_in);
      if (hit_vec[w]) hit_way = VPW'(w);
    end
  end

  assign hit        = |hit_vec;
  assign hit_word   = data[hit_way][set_idx][word_off];
  assign cache_dout = hit ? hit_word : 32'h0;

  logic lookup, store_hit, miss;
  assign lookup    = (state_q == ST_IDLE) && cpu_req;
  assign store_hit = lookup && hit && WE;
  assign miss      = lookup && !hit;
  assign stall     = (state_q != ST_IDLE) || miss;

  // Victim: lowest invalid way, else the round-robin pointer.
  logic [VPW-1:0] vic_way;
  logic           vic_found;
  logic           vic_dirty;

  always_comb begin
    vic_way   = vptr_q[set_idx];
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found && !valid_q[set_idx][w]) begin
        vic_way   = VPW'(w);
        vic_found = 1'b1;
      end
    end
  end

  assign vic_dirty = valid_q[set_idx][vic_way] && dirty_q[set_idx][vic_way];

  dcache_store_merge u_merge (
    .old_word (hit_word),
    .wd       (WD[31:0]),
    .ctrl     (AddressingControl),
    .boff     (A[1:0]),
    .merged   (merged)
  );

  function automatic logic [XLEN-1:0] line_addr(input logic [TAGW-1:0] t,
                                                input logic [SB-1:0]   s,
                                                input logic [WBW-1:0]  w);
    return (XLEN'(t) << (2 + WB + SB)) | (XLEN'(s) << (2 + WB)) | (XLEN'(w) << 2);
  endfunction

  logic rf_we, last;
  assign rf_we = (state_q == ST_REFILL) && mem_ack;
  assign last  = (wcnt_q == LAST_WORD);

  // Line data and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (store_hit) data[hit_way][set_idx][word_off] <= merged;
    if (rf_we) data[vic_q][set_q][wcnt_q] <= mem_rd;
    if (rf_we && last) tags[vic_q][set_q] <= mtag_q;
  end

  // Miss FSM with registered memory port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      vic_q    <= '0;
      set_q    <= '0;
      mtag_q   <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (store_hit) begin
            dirty_q[set_idx][hit_way] <= 1'b1;
          end else if (miss) begin
            vic_q   <= vic_way;
            set_q   <= set_idx;
            mtag_q  <= tag_in;
            wcnt_q  <= '0;
            mem_req <= 1'b1;
            if (vic_dirty) begin
              state_q  <= ST_WRITEBACK;
              mem_we   <= 1'b1;
              mem_addr <= line_addr(tags[vic_way][set_idx], set_idx, '0);
              mem_wd   <= data[vic_way][set_idx][0];
            end else begin
              state_q  <= ST_REFILL;
              mem_we   <= 1'b0;
              mem_addr <= line_addr(tag_in, set_idx, '0);
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack) begin
            if (last) begin
              // Keep mem_req high; the refill starts with no gap.
              dirty_q[set_q][vic_q] <= 1'b0;
              state_q  <= ST_REFILL;
              mem_we   <= 1'b0;
              wcnt_q   <= '0;
              mem_addr <= line_addr(mtag_q, set_q, '0);
            end else begin
              wcnt_q   <= wcnt_q + 1'b1;
              mem_addr <= line_addr(tags[vic_q][set_q], set_q, wcnt_q + 1'b1);
              mem_wd   <= data[vic_q][set_q][wcnt_q + 1'b1];
            end
          end
        end
        ST_REFILL: begin
          if (mem_ack) begin
            if (last) begin
              valid_q[set_q][vic_q] <= 1'b1;
              dirty_q[set_q][vic_q] <= 1'b0;
              vptr_q[set_q]         <= vptr_q[set_q] + 1'b1;
              mem_req <= 1'b0;
              wcnt_q  <= '0;
              state_q <= ST_IDLE;
            end else begin
              wcnt_q   <= wcnt_q + 1'b1;
              mem_addr <= line_addr(mtag_q, set_q, wcnt_q + 1'b1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hits_q, misses_q, wbs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      if (lookup && hit)     hits_q   <= hits_q + 1'b1;
      if (miss)              misses_q <= misses_q + 1'b1;
      if (miss && vic_dirty) wbs_q    <= wbs_q + 1'b1;
    end
  end

  assign hit_count  = hits_q;
  assign miss_count = misses_q;
  assign wb_count   = wbs_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
  assign wb_count   = 32'h0;
`endif

endmodule
